// File: rtl/wb_write_scheduler_pkg.sv
// Shared constants and the write-back entry type for wb_write_scheduler.
package wb_write_scheduler_pkg;

  localparam int NUM_ARCH_REGS = 15;
  localparam int PC_IDX        = 15;
  localparam int WB_DATA_W     = 32;
  localparam int WB_ADDR_W     = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_scheduler_fifo.sv
// wb_fifo: dual-push / single-pop circular buffer of pending writes.
// Entries are exported in age order (index 0 = head); WB_FWD_EN adds data.
import wb_write_scheduler_pkg::*;

module wb_write_scheduler_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push0,
  input  logic [ADDR_W-1:0]              push0_dest,
  input  logic [DATA_W-1:0]              push0_data,
  input  logic                           push1,
  input  logic [ADDR_W-1:0]              push1_dest,
  input  logic [DATA_W-1:0]              push1_data,
  input  logic                           pop,
  output logic [$clog2(DEPTH):0]         count,
  output logic [ADDR_W-1:0]              head_dest,
  output logic [DATA_W-1:0]              head_data,
  output logic [DEPTH-1:0]               age_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]   age_dest
`ifdef WB_FWD_EN
  ,
  output logic [DEPTH-1:0][DATA_W-1:0]   age_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] mem_dest;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic [PW-1:0]                rd_ptr;
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                wr_ptr1;

  // second push lands behind the first when both fire
  assign wr_ptr1 = wr_ptr + PW'(push0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      count  <= count + CW'(push0)
              + CW'(push1) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push0) begin
      mem_dest[wr_ptr] <= push0_dest;
      mem_data[wr_ptr] <= push0_data;
    end
    if (push1) begin
      mem_dest[wr_ptr1] <= push1_dest;
      mem_data[wr_ptr1] <= push1_data;
    end
  end

  assign head_dest = mem_dest[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PW-1:0] idx;
    assign idx          = rd_ptr + PW'(k);
    assign age_valid[k] = CW'(k) < count;
    assign age_dest[k]  = mem_dest[idx];
`ifdef WB_FWD_EN
    assign age_data[k]  = mem_data[idx];
`endif
  end

endmodule

// File: rtl/wb_write_scheduler.sv
// Merges load returns and ALU results onto the single register-file write port.
// Define WB_FWD_EN to add the fwd_src/fwd_hit/fwd_data lookup.
import wb_write_scheduler_pkg::*;

module wb_write_scheduler #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_dest,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     stall,
  output logic [ADDR_W-1:0]        Dest_wb,
  output logic [DATA_W-1:0]        Result_WB,
  output logic                     writeBackEn,
  output logic [NUM_ARCH_REGS-1:0] pending_mask,
  output logic                     drop_pc
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]        fwd_src,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC = ADDR_W'(PC_IDX);

  logic [CW-1:0]              count;
  logic [ADDR_W-1:0]          head_dest;
  logic [DATA_W-1:0]          head_data;
  logic [DEPTH-1:0]           age_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] age_dest;
`ifdef WB_FWD_EN
  logic [DEPTH-1:0][DATA_W-1:0] age_data;
`endif

  logic              ld_ok;
  logic              alu_ok;
  logic              any_ok;
  logic              both_ok;
  logic              have;
  logic              pc_hit;
  logic [ADDR_W-1:0] e0_dest;
  logic [DATA_W-1:0] e0_data;
  logic              push0;
  logic              push1;
  logic [ADDR_W-1:0] p0_dest;
  logic [DATA_W-1:0] p0_data;

  // loads are older than a same-cycle ALU result
  assign ld_ok   = ld_valid && (ld_dest != PC);
  assign alu_ok  = alu_valid && (alu_dest != PC);
  assign any_ok  = ld_ok || alu_ok;
  assign both_ok = ld_ok && alu_ok;
  assign have    = (count != '0);
  assign pc_hit  = (ld_valid && (ld_dest == PC))
                || (alu_valid && (alu_dest == PC));
  assign e0_dest = ld_ok ? ld_dest : alu_dest;
  assign e0_data = ld_ok ? ld_data : alu_result;

  always_comb begin
    push0   = 1'b0;
    push1   = 1'b0;
    p0_dest = e0_dest;
    p0_data = e0_data;
    if (have) begin
      push0 = any_ok;
      push1 = both_ok && (count != CW'(DEPTH));
    end else begin
      push0   = both_ok;
      p0_dest = alu_dest;
      p0_data = alu_result;
    end
  end

  wb_write_scheduler_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push0      (push0),
    .push0_dest (p0_dest),
    .push0_data (p0_data),
    .push1      (push1),
    .push1_dest (alu_dest),
    .push1_data (alu_result),
    .pop        (have),
    .count      (count),
    .head_dest  (head_dest),
    .head_data  (head_data),
    .age_valid  (age_valid),
    .age_dest   (age_dest)
`ifdef WB_FWD_EN
    ,
    .age_data   (age_data)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeBackEn <= 1'b0;
      Dest_wb     <= '0;
      Result_WB   <= '0;
      drop_pc     <= 1'b0;
    end else begin
      drop_pc <= pc_hit;
      if (have) begin
        writeBackEn <= 1'b1;
        Dest_wb     <= head_dest;
        Result_WB   <= head_data;
      end else if (any_ok) begin
        writeBackEn <= 1'b1;
        Dest_wb     <= e0_dest;
        Result_WB   <= e0_data;
      end else begin
        writeBackEn <= 1'b0;
      end
    end
  end

  // two free slots remain whenever stall is low
  assign stall = (count >= CW'(DEPTH - 1));

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      if (writeBackEn && (Dest_wb == ADDR_W'(r)))
        pending_mask[r] = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
        if (age_valid[k] && (age_dest[k] == ADDR_W'(r)))
          pending_mask[r] = 1'b1;
      end
    end
  end

`ifdef WB_FWD_EN
  // later matches overwrite earlier ones: youngest wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_src != PC) begin
      if (writeBackEn && (Dest_wb == fwd_src)) begin
        fwd_hit  = 1'b1;
        fwd_data = Result_WB;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (age_valid[k] && (age_dest[k] == fwd_src)) begin
          fwd_hit  = 1'b1;
          fwd_data = age_data[k];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Scoreboard bench for wb_write_scheduler; expected writes queue up as
// stimulus is driven and are popped when writeBackEn presents them.
import wb_write_scheduler_pkg::*;

module tb_wb_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_dest;
  logic [31:0] alu_result;
  logic        ld_valid;
  logic [3:0]  ld_dest;
  logic [31:0] ld_data;
  logic        stall;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;
  logic        writeBackEn;
  logic [14:0] pending_mask;
  logic        drop_pc;
`ifdef WB_FWD_EN
  logic [3:0]  fwd_src;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  wb_entry_t   exp_q[$];
  wb_entry_t   mon_e;
  logic [14:0] mon_m;

  always #5 clk = ~clk;

  wb_write_scheduler #(
    .DEPTH  (4),
    .DATA_W (32),
    .ADDR_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_dest     (alu_dest),
    .alu_result   (alu_result),
    .ld_valid     (ld_valid),
    .ld_dest      (ld_dest),
    .ld_data      (ld_data),
    .stall        (stall),
    .Dest_wb      (Dest_wb),
    .Result_WB    (Result_WB),
    .writeBackEn  (writeBackEn),
    .pending_mask (pending_mask),
    .drop_pc      (drop_pc)
`ifdef WB_FWD_EN
    ,
    .fwd_src      (fwd_src),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
`endif
  );

  // every queued write is inside the DUT by the negedge after it is driven
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (writeBackEn === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL spurious_write: dest=%0d data=%h, no write expected",
                   Dest_wb, Result_WB);
        end else begin
          mon_m = '0;
          foreach (exp_q[i]) mon_m[exp_q[i].dest] = 1'b1;
          mon_e = exp_q.pop_front();
          if (Dest_wb !== mon_e.dest || Result_WB !== mon_e.data
              || pending_mask !== mon_m) begin
            $display("FAIL wb_write: got d=%0d x=%h m=%h, want d=%0d x=%h m=%h",
                     Dest_wb, Result_WB, pending_mask,
                     mon_e.dest, mon_e.data, mon_m);
          end else begin
            n_pass++;
          end
        end
      end else if (exp_q.size() != 0) begin
        n_chk++;
        $display("FAIL lost_write: wbe=%b, want 1 (pending %0d)",
                 writeBackEn, exp_q.size());
      end
    end
  end

  task automatic set_idle();
    ld_valid  = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic cyc(input bit lv, input logic [3:0] ldd,
                     input logic [31:0] ldx, input bit av,
                     input logic [3:0] ald, input logic [31:0] alx);
    @(negedge clk);
    #1;
    if (lv || av) begin
      n_chk++;
      if (stall !== 1'b0)
        $display("FAIL protocol_stall: stall=%b, want 0", stall);
      else
        n_pass++;
    end
    ld_valid   = lv;
    ld_dest    = ldd;
    ld_data    = ldx;
    alu_valid  = av;
    alu_dest   = ald;
    alu_result = alx;
    if (lv && ldd != 4'd15) exp_q.push_back('{dest: ldd, data: ldx});
    if (av && ald != 4'd15) exp_q.push_back('{dest: ald, data: alx});
  endtask

  task automatic wait_drain();
    @(negedge clk);
    #1;
    set_idle();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #2;
    end
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL drain_timeout: pending=%0d, want 0", exp_q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    ld_dest = '0; ld_data = '0; alu_dest = '0; alu_result = '0;
`ifdef WB_FWD_EN
    fwd_src = '0;
`endif
    repeat (2) @(negedge clk);
    n_chk++;
    if ({writeBackEn, Dest_wb, Result_WB, drop_pc, stall, pending_mask}
        !== '0)
      $display("FAIL reset_state: wbe=%b d=%0d x=%h drop=%b st=%b m=%h, want 0",
               writeBackEn, Dest_wb, Result_WB, drop_pc, stall, pending_mask);
    else
      n_pass++;
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    cyc(0, 0, 0, 1, 4'd3, 32'hAA);
    @(negedge clk);
    #1;
    set_idle();
    @(negedge clk);
    #1;
    n_chk++;
    if (writeBackEn !== 1'b0 || pending_mask !== '0)
      $display("FAIL single_after: wbe=%b m=%h, want 0 0",
               writeBackEn, pending_mask);
    else
      n_pass++;
  endtask

  task automatic test_order();
    cyc(1, 4'd5, 32'h11, 1, 4'd6, 32'h22);
    @(negedge clk);
    #1;
    set_idle();
    n_chk++;
    if (stall !== 1'b0)
      $display("FAIL order_stall: stall=%b, want 0", stall);
    else
      n_pass++;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    cyc(1, 4'd1, 32'h101, 1, 4'd2, 32'h202);
    cyc(1, 4'd3, 32'h303, 1, 4'd4, 32'h404);
    cyc(1, 4'd7, 32'h707, 1, 4'd8, 32'h808);
    @(negedge clk);
    #1;
    n_chk++;
    if (stall !== 1'b1)
      $display("FAIL b2b_stall: stall=%b, want 1", stall);
    else
      n_pass++;
    set_idle();
    wait_drain();
    n_chk++;
    if (stall !== 1'b0)
      $display("FAIL b2b_stall_clear: stall=%b, want 0", stall);
    else
      n_pass++;
  endtask

  task automatic test_drop_pc();
    cyc(0, 0, 0, 1, 4'd15, 32'h55);
    @(negedge clk);
    #1;
    set_idle();
    n_chk++;
    if (drop_pc !== 1'b1 || writeBackEn !== 1'b0 || pending_mask !== '0)
      $display("FAIL drop_pulse: drop=%b wbe=%b m=%h, want 1 0 0",
               drop_pc, writeBackEn, pending_mask);
    else
      n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (drop_pc !== 1'b0)
      $display("FAIL drop_clear: drop=%b, want 0", drop_pc);
    else
      n_pass++;
    cyc(1, 4'd15, 32'h66, 1, 4'd9, 32'h77);
    @(negedge clk);
    #1;
    set_idle();
    n_chk++;
    if (drop_pc !== 1'b1)
      $display("FAIL drop_mixed: drop=%b, want 1", drop_pc);
    else
      n_pass++;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    cyc(1, 4'd10, 32'hA0, 1, 4'd11, 32'hB0);
    cyc(1, 4'd12, 32'hC0, 1, 4'd13, 32'hD0);
    @(negedge clk);
    #1;
    set_idle();
    #2;
    rst    = 1'b1;
    mon_en = 1'b0;
    #1;
    n_chk++;
    if ({writeBackEn, Dest_wb, Result_WB, drop_pc, stall, pending_mask}
        !== '0)
      $display("FAIL mid_reset: wbe=%b d=%0d x=%h m=%h, want 0",
               writeBackEn, Dest_wb, Result_WB, pending_mask);
    else
      n_pass++;
    exp_q.delete();
    @(negedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (writeBackEn !== 1'b0 || pending_mask !== '0)
      $display("FAIL post_reset: wbe=%b m=%h, want 0 0",
               writeBackEn, pending_mask);
    else
      n_pass++;
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    cyc(1, 4'd1, 32'h01, 1, 4'd4, 32'h04);
    cyc(1, 4'd2, 32'h10, 1, 4'd2, 32'h20);
    @(negedge clk);
    #1;
    set_idle();
    fwd_src = 4'd2;
    #1;
    n_chk++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h20)
      $display("FAIL fwd_young: hit=%b data=%h, want 1 00000020",
               fwd_hit, fwd_data);
    else
      n_pass++;
    fwd_src = 4'd7;
    #1;
    n_chk++;
    if (fwd_hit !== 1'b0 || fwd_data !== '0)
      $display("FAIL fwd_miss: hit=%b data=%h, want 0 0", fwd_hit, fwd_data);
    else
      n_pass++;
    fwd_src = 4'd4;
    #1;
    n_chk++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h04)
      $display("FAIL fwd_outreg: hit=%b data=%h, want 1 00000004",
               fwd_hit, fwd_data);
    else
      n_pass++;
    wait_drain();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_order();
    test_back_to_back();
    test_drop_pc();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    repeat (2) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL final_queue: pending=%0d, want 0", exp_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_write_scheduler.md
Name: wb_write_scheduler

Overview:
- Write-back side of the register file's single write port.
- Merges two result streams into one in-order write per cycle on Dest_wb/Result_WB/writeBackEn:
  - ALU results from the EXE/MEM path.
  - Multi-cycle load returns from data memory.
- Buffers collisions in a small FIFO and exports a pending-write scoreboard to hazard detection.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- DATA_W, 32, result width.
- ADDR_W, 4, register index width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result offered this cycle.
- alu_dest  in  ADDR_W  ALU destination register.
- alu_result  in  DATA_W  ALU result value.
- ld_valid  in  1  load data returned this cycle.
- ld_dest  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load data value.
- stall  out  1  upstream must hold off new results.
- Dest_wb  out  ADDR_W  register-file write index.
- Result_WB  out  DATA_W  register-file write data.
- writeBackEn  out  1  register-file write strobe.
- pending_mask  out  15  bit r = a write to r is buffered or presenting.
- drop_pc  out  1  one-cycle pulse: a write to r15 was discarded.

Behaviour:
- Reset (async, any time, including mid-burst):
  - FIFO flushed, count=0.
  - writeBackEn=0, Dest_wb=0, Result_WB=0, drop_pc=0, stall=0, pending_mask=0.
- Same-cycle ordering: ld is older than alu (it belongs to an earlier instruction). The accepted sequence per posedge is {ld, alu}, skipping invalid sources.
- Destination 15 (PC) is never written:
  - The entry is discarded and drop_pc=1 for the next cycle.
  - A discarded entry consumes no FIFO slot and no output slot.
- Output register, each posedge:
  - If count>0: present FIFO head, pop it, writeBackEn=1.
  - Else if the accepted sequence is non-empty: its first element bypasses the FIFO to the output, writeBackEn=1.
  - Else writeBackEn=0; Dest_wb/Result_WB hold their last values.
- Accepted elements not taken by the output are pushed in order. Up to 2 pushes and 1 pop per cycle; count updates by pushes minus pop.
- Latency:
  - 1 cycle minimum: input sampled at edge N, writeBackEn high after edge N.
  - Each buffered entry adds 1 cycle.
- Timing to the register file: outputs change only on posedge and are stable across the following negedge, where the register file samples its write port.
- stall = (count >= DEPTH-1), decoded from registered count, so room for two pushes is always guaranteed.
  - Upstream must keep alu_valid/ld_valid low while stall=1.
  - Inputs arriving when no slot is free are ignored; the bench flags this as a protocol error.
- FIFO pointers wrap modulo DEPTH; count saturates at 0..DEPTH by construction.
- pending_mask (combinational from registered state):
  - OR of one-hot(dest) over valid FIFO entries, plus the output register while writeBackEn=1.
  - Bit r stays set until the last pending write to r has been presented.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, adds ports:
  - fwd_src  in  ADDR_W  register being read by ID.
  - fwd_hit  out  1
  - fwd_data  out  DATA_W
- Lookup is combinational over the output register and FIFO entries:
  - fwd_hit=1 when any pending write targets fwd_src.
  - fwd_data = youngest matching value (FIFO tail side beats head side, which beats the output register).
  - fwd_hit=0 and fwd_data=0 when there is no match or fwd_src=15.
- When undefined: ports absent, no lookup logic.

Decomposition:
- Shared package (e.g. arm_pkg):
  - NUM_ARCH_REGS=15, PC_IDX=15, DATA_W/ADDR_W defaults.
  - wb_entry_t struct {dest, data}.
- One natural sub-module: wb_fifo (dual-push/single-pop circular buffer exposing count, head, per-entry valid/dest for the scoreboard).
- Arbitration, bypass and scoreboard stay in the top.

Test Plan:
- Reset, then alu_valid=1 alu_dest=3 alu_result=0xAA for one cycle -> next cycle writeBackEn=1, Dest_wb=3, Result_WB=0xAA; pending_mask[3]=1 for that cycle only.
- Same cycle ld(5,0x11) and alu(6,0x22) -> writes appear in order r5=0x11 then r6=0x22 on consecutive cycles; count peaks at 1.
- Three consecutive cycles of dual valid, DEPTH=4 -> stall rises when count reaches 3; all 6 writes drain in order; no loss.
- alu_dest=15, alu_result=0x55 -> drop_pc pulses 1 cycle; writeBackEn stays 0; pending_mask unchanged.
- With FIFO holding 2 entries, assert rst mid-cycle -> outputs and pending_mask go to 0 immediately; no stale writes appear after release.
- WB_FWD_EN defined: buffered r2=0x10 (older) and r2=0x20 (younger), fwd_src=2 -> fwd_hit=1, fwd_data=0x20; fwd_src=7 -> fwd_hit=0.
